// File: rtl/ysyx_22051013_regfile_wbctl.sv
// Register file write-back arbiter and long-latency scoreboard.
// Pipeline write-back (A) always wins the single write port; long-latency results (B) wait in a one-entry buffer.
module ysyx_22051013_regfile_wbctl #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned AW         = 5,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic            issue_long,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   issue_rs1,
    input  logic            issue_rs1_en,
    input  logic [AW-1:0]   issue_rs2,
    input  logic            issue_rs2_en,
    output logic            issue_stall,
    input  logic            a_valid,
    input  logic [AW-1:0]   a_addr,
    input  logic [XLEN-1:0] a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [AW-1:0]   b_addr,
    input  logic [XLEN-1:0] b_data,
    output logic            rf_wen,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [31:0]     busy
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic            buf_v;
    logic [AW-1:0]   buf_addr;
    logic [XLEN-1:0] buf_data;
    logic [3:0]      starve_cnt;
    logic [31:0]     busy_nxt;

    logic drain;
    logic xfer;
    logic fire;
    logic starve;

    assign drain   = buf_v && !a_valid;
    assign b_ready = !buf_v || drain;
    assign xfer    = b_valid && b_ready;
    assign starve  = starve_cnt >= STARVE_LIM;
    assign fire    = issue_valid && !issue_stall;

    assign issue_stall = (issue_rs1_en && busy[issue_rs1])
                       || (issue_rs2_en && busy[issue_rs2])
                       || (issue_long && busy[issue_rd])
                       || (issue_valid && starve);

    // Clear is applied before set so a same-edge collision leaves the bit set.
    always_comb begin
        busy_nxt = busy;
        if (drain)
            busy_nxt[buf_addr] = 1'b0;
        if (fire && issue_long && (issue_rd != '0))
            busy_nxt[issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_wen     <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            buf_v      <= 1'b0;
            buf_addr   <= '0;
            buf_data   <= '0;
            starve_cnt <= '0;
            busy       <= '0;
        end else begin
            busy <= busy_nxt;

            if (a_valid) begin
                rf_wen   <= (a_addr != '0);
                rf_waddr <= a_addr;
                rf_wdata <= a_data;
            end else if (drain) begin
                rf_wen   <= (buf_addr != '0);
                rf_waddr <= buf_addr;
                rf_wdata <= buf_data;
            end else begin
                rf_wen <= 1'b0;
            end

            if (xfer) begin
                buf_v    <= 1'b1;
                buf_addr <= b_addr;
                buf_data <= b_data;
            end else if (drain) begin
                buf_v <= 1'b0;
            end

            if (!buf_v || drain)
                starve_cnt <= '0;
            else if (starve_cnt != 4'hf)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_ysyx_22051013_regfile_wbctl.sv
// Self-checking bench: directed table and sequences plus randomized traffic against a queue-based model.
module tb_ysyx_22051013_regfile_wbctl;

    localparam int unsigned STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_valid, issue_long, issue_rs1_en, issue_rs2_en;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2;
    logic        issue_stall;
    logic        a_valid, b_valid, b_ready;
    logic [4:0]  a_addr, b_addr;
    logic [63:0] a_data, b_data;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [31:0] busy;

    ysyx_22051013_regfile_wbctl #(
        .XLEN(64), .AW(5), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_long(issue_long), .issue_rd(issue_rd),
        .issue_rs1(issue_rs1), .issue_rs1_en(issue_rs1_en),
        .issue_rs2(issue_rs2), .issue_rs2_en(issue_rs2_en),
        .issue_stall(issue_stall),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        iv;
        logic        il;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic        e1;
        logic [4:0]  rs2;
        logic        e2;
        logic        av;
        logic [4:0]  aa;
        logic [63:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [63:0] bd;
    } in_t;

    typedef struct {
        in_t         in;
        logic        ewen;
        logic [4:0]  ewaddr;
        logic [63:0] ewdata;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending set, FIFO of buffered B results, blocked-cycle count
    bit          pend[32];
    logic [4:0]  bq_a[$];
    logic [63:0] bq_d[$];
    int          blocked;
    logic        m_wen;
    logic [4:0]  m_waddr;
    logic [63:0] m_wdata;
    logic        last_stall, last_ready;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = pend[i];
        return v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) pend[i] = 0;
        bq_a.delete();
        bq_d.delete();
        blocked = 0;
        m_wen = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
    endtask

    task automatic drive(input in_t x);
        issue_valid = x.iv; issue_long = x.il; issue_rd = x.rd;
        issue_rs1 = x.rs1; issue_rs1_en = x.e1;
        issue_rs2 = x.rs2; issue_rs2_en = x.e2;
        a_valid = x.av; a_addr = x.aa; a_data = x.ad;
        b_valid = x.bv; b_addr = x.ba; b_data = x.bd;
    endtask

    task automatic check_regs();
        chk("rf_wen", {63'd0, rf_wen}, {63'd0, m_wen});
        chk("rf_waddr", {59'd0, rf_waddr}, {59'd0, m_waddr});
        chk("rf_wdata", rf_wdata, m_wdata);
        chk("busy", {32'd0, busy}, {32'd0, m_busy()});
    endtask

    // One clock cycle: drive, check combinational outputs, advance model, check registered outputs
    task automatic cyc(input in_t x);
        bit has_buf, drn, rdy, stl;
        drive(x);
        #1;
        has_buf = (bq_a.size() != 0);
        drn = has_buf && !x.av;
        rdy = !has_buf || drn;
        stl = (x.e1 && pend[x.rs1]) || (x.e2 && pend[x.rs2]) || (x.il && pend[x.rd])
              || (x.iv && blocked >= int'(STARVE_MAX));
        chk("issue_stall", {63'd0, issue_stall}, {63'd0, stl});
        chk("b_ready", {63'd0, b_ready}, {63'd0, rdy});
        last_stall = issue_stall;
        last_ready = b_ready;

        if (x.av) begin
            m_wen = (x.aa != 0); m_waddr = x.aa; m_wdata = x.ad;
        end else if (drn) begin
            m_waddr = bq_a.pop_front();
            m_wdata = bq_d.pop_front();
            m_wen = (m_waddr != 0);
            pend[m_waddr] = 0;
        end else begin
            m_wen = 1'b0;
        end
        if (has_buf && x.av) blocked++;
        else blocked = 0;
        if (x.iv && !stl && x.il && x.rd != 0) pend[x.rd] = 1;
        if (x.bv && rdy) begin
            bq_a.push_back(x.ba);
            bq_d.push_back(x.bd);
        end

        @(posedge clk);
        #1;
        check_regs();
    endtask

    function automatic in_t mk_a(logic av, logic [4:0] aa, logic [63:0] ad);
        in_t v;
        v = '0;
        v.av = av; v.aa = aa; v.ad = ad;
        return v;
    endfunction

    vec_t tbl[6];
    in_t  v;

    initial begin
        drive('0);
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset rf_wen", {63'd0, rf_wen}, 64'd0);
        chk("reset busy", {32'd0, busy}, 64'd0);
        chk("reset b_ready", {63'd0, b_ready}, 64'd1);
        chk("reset issue_stall", {63'd0, issue_stall}, 64'd0);
        @(posedge clk);
        #1;

        // Source A only
        tbl[0] = '{mk_a(1'b1, 5'd5, 64'h1234), 1'b1, 5'd5, 64'h1234};
        tbl[1] = '{mk_a(1'b1, 5'd0, 64'h55), 1'b0, 5'd0, 64'h55};
        tbl[2] = '{mk_a(1'b0, 5'd9, 64'h99), 1'b0, 5'd0, 64'h55};
        tbl[3] = '{mk_a(1'b1, 5'd31, '1), 1'b1, 5'd31, '1};
        tbl[4] = '{mk_a(1'b0, 5'd0, 64'h0), 1'b0, 5'd31, '1};
        tbl[5] = '{mk_a(1'b1, 5'd1, 64'h0), 1'b1, 5'd1, 64'h0};
        for (int i = 0; i < 6; i++) begin
            cyc(tbl[i].in);
            chk($sformatf("tbl%0d wen", i), {63'd0, rf_wen}, {63'd0, tbl[i].ewen});
            chk($sformatf("tbl%0d waddr", i), {59'd0, rf_waddr}, {59'd0, tbl[i].ewaddr});
            chk($sformatf("tbl%0d wdata", i), rf_wdata, tbl[i].ewdata);
        end

        // B path and scoreboard on x7
        v = '0; v.iv = 1; v.il = 1; v.rd = 7;
        cyc(v);
        chk("busy7 set", {63'd0, busy[7]}, 64'd1);
        v = '0; v.iv = 1; v.rs1 = 7; v.e1 = 1; v.bv = 1; v.ba = 7; v.bd = 64'hDEAD;
        cyc(v);
        chk("raw stall", {63'd0, last_stall}, 64'd1);
        chk("b accept", {63'd0, last_ready}, 64'd1);
        chk("no early wen", {63'd0, rf_wen}, 64'd0);
        v = '0; v.iv = 1; v.rs1 = 7; v.e1 = 1;
        cyc(v);
        chk("raw stall held", {63'd0, last_stall}, 64'd1);
        chk("b drain wen", {63'd0, rf_wen}, 64'd1);
        chk("b drain addr", {59'd0, rf_waddr}, 64'd7);
        chk("b drain data", rf_wdata, 64'hDEAD);
        chk("busy7 clear", {63'd0, busy[7]}, 64'd0);
        cyc(v);
        chk("raw release", {63'd0, last_stall}, 64'd0);

        // Collision and starvation
        v = mk_a(1'b1, 5'd2, 64'hA0); v.bv = 1; v.ba = 3; v.bd = 64'hB3;
        cyc(v);
        for (int i = 0; i < 6; i++) begin
            v = mk_a(1'b1, 5'd2, 64'hA0 + 64'(i)); v.iv = 1;
            cyc(v);
            chk($sformatf("starve ready%0d", i), {63'd0, last_ready}, 64'd0);
            chk($sformatf("starve stall%0d", i), {63'd0, last_stall}, {63'd0, (i >= 4)});
        end
        v = '0; v.iv = 1;
        cyc(v);
        chk("starve drain ready", {63'd0, last_ready}, 64'd1);
        chk("starve drain addr", {59'd0, rf_waddr}, 64'd3);
        chk("starve drain data", rf_wdata, 64'hB3);
        cyc(v);
        chk("starve cleared", {63'd0, last_stall}, 64'd0);

        // WAW on x9
        v = '0; v.iv = 1; v.il = 1; v.rd = 9;
        cyc(v);
        cyc(v);
        chk("waw stall", {63'd0, last_stall}, 64'd1);
        chk("waw busy", {32'd0, busy}, 64'h200);
        v = '0; v.bv = 1; v.ba = 9; v.bd = 64'h9;
        cyc(v);
        cyc('0);

        // Drain and accept on the same edge
        v = mk_a(1'b1, 5'd4, 64'h4); v.bv = 1; v.ba = 10; v.bd = 64'h10;
        cyc(v);
        v = '0; v.bv = 1; v.ba = 11; v.bd = 64'h11;
        cyc(v);
        chk("simul ready", {63'd0, last_ready}, 64'd1);
        chk("simul first", {59'd0, rf_waddr}, 64'd10);
        cyc('0);
        chk("simul second", {59'd0, rf_waddr}, 64'd11);
        chk("simul second wen", {63'd0, rf_wen}, 64'd1);

        // b_addr 0 drains with rf_wen low
        v = '0; v.bv = 1; v.ba = 0; v.bd = 64'h77;
        cyc(v);
        cyc('0);
        chk("b x0 wen", {63'd0, rf_wen}, 64'd0);

        // Mid-cycle asynchronous reset with a buffered write and pending bit
        v = mk_a(1'b1, 5'd6, 64'h66); v.iv = 1; v.il = 1; v.rd = 12; v.bv = 1; v.ba = 12; v.bd = 64'hC;
        cyc(v);
        drive(v);
        #2 rst = 1'b0;
        #1;
        chk("async rf_wen", {63'd0, rf_wen}, 64'd0);
        chk("async rf_waddr", {59'd0, rf_waddr}, 64'd0);
        chk("async rf_wdata", rf_wdata, 64'd0);
        chk("async busy", {32'd0, busy}, 64'd0);
        m_reset();
        #2;
        drive('0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post reset b_ready", {63'd0, b_ready}, 64'd1);
        chk("post reset busy", {32'd0, busy}, 64'd0);
        chk("post reset stall", {63'd0, issue_stall}, 64'd0);
        cyc('0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            v = '0;
            v.iv  = ($urandom_range(0, 99) < 70);
            v.il  = ($urandom_range(0, 99) < 30);
            v.rd  = 5'($urandom_range(0, 7));
            v.rs1 = 5'($urandom_range(0, 7));
            v.e1  = 1'($urandom);
            v.rs2 = 5'($urandom_range(0, 7));
            v.e2  = 1'($urandom);
            v.av  = ($urandom_range(0, 99) < 60);
            v.aa  = 5'($urandom);
            v.ad  = {$urandom, $urandom};
            v.bv  = 1'($urandom);
            v.ba  = 5'($urandom_range(0, 7));
            v.bd  = {$urandom, $urandom};
            cyc(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
